alu_regfile_seq: RTL and testbench
==================================

// Module: alu_regfile_seq
// PURPOSE
//   Parametrised register-file ALU datapath: NREGS x WIDTH registers, valid/ready command
//   port, registered result write-back, a sticky flag register and a response pulse.
//   Adds shifts by amount, arithmetic right shift, add-with-carry and an iterative multiply.
//   Sits between the sequencer (command source) and the debug/display path (read port).
// PARAMETERS
//   WIDTH   8   datapath and register width, >=4
//   NREGS   4   number of registers, power of two, >=2
//   ADDR_W  $clog2(NREGS)  register index width (derived, not overridden)
// PORTS
//   clk          in   1       clock
//   rst_n        in   1       reset, asynchronous, active-low
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       block can accept a command
//   cmd_op       in   4       opcode (table below)
//   cmd_rd       in   ADDR_W  destination register
//   cmd_ra       in   ADDR_W  source A register
//   cmd_rb       in   ADDR_W  source B register
//   cmd_use_imm  in   1       1: operand B = cmd_imm, 0: operand B = reg[cmd_rb]
//   cmd_imm      in   WIDTH   immediate operand
//   rsp_valid    out  1       one-cycle pulse: command completed
//   rsp_data     out  WIDTH   result of completed command (held until next completion)
//   rsp_err      out  1       completed command was illegal (valid with rsp_valid)
//   flags        out  4       {Z,N,C,V}, registered
//   rd_sel       in   ADDR_W  debug read index
//   rd_data      out  WIDTH   reg[rd_sel], combinational
// BEHAVIOUR
//   Reset: all regs 0, FSM IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, flags=0.
//   Handshake: accept when cmd_valid & cmd_ready (cycle T); A=reg[ra], B latched at T.
//   FSM: IDLE -> EXEC on accept of any non-MUL op; IDLE -> MUL on accept of MUL.
//     EXEC: 1 cycle; writes reg[rd], flags, rsp_*, pulses rsp_valid at T+1; -> IDLE.
//     MUL: shift-add, one multiplier bit per cycle, WIDTH cycles; completion at T+WIDTH.
//   cmd_ready=1 only in IDLE (so low during the completion cycle; next accept at T+2 for EXEC).
//   Ops: 0 ADD a+b | 1 SUB a-b | 2 AND | 3 OR | 4 XOR | 5 NOT a | 6 SHL a<<b[S-1:0]
//     7 SHR logical | 8 SAR arithmetic | 9 MUL low WIDTH bits of a*b | 10 MOV b
//     11 ADC a+b+flags.C | 12-15 illegal. S=$clog2(WIDTH); shift amount uses only low S bits.
//   Flags on legal completion: Z=(result==0), N=result[WIDTH-1].
//     ADD/ADC: C=carry out, V=signed overflow. SUB: C=1 when no borrow (a>=b unsigned), V=signed ovf.
//     SHL/SHR/SAR: C=last bit shifted out (0 if amount 0), V=0. MUL: C=1 if high half nonzero, V=0.
//     AND/OR/XOR/NOT/MOV: C=0, V=0.
//   Illegal op: 1-cycle EXEC, rsp_valid=1, rsp_err=1, rsp_data=0, no reg write, flags unchanged.
//   rd==ra or rd==rb legal: operands already latched, result overwrites at completion.
//   rd_data shows pre-write value in completion cycle, new value from next cycle.
//   Async reset mid-MUL/EXEC: operation aborted, no write, no rsp_valid after release.
// TESTING
//   ADD r0=0x7F, imm 0x01 -> rsp_data=0x80, flags Z0 N1 C0 V1, rd_data(r0)=0x80 at T+2.
//   SUB 0x00-0x01 -> 0xFF, C=0 V=0 N=1; then ADC 0xFF+0x00 with C=0 -> 0xFF; with C=1 -> 0x00 Z=1 C=1.
//   MUL 13*11 (WIDTH=8) -> rsp_valid exactly at T+8, rsp_data=0x8F, C=0; cmd_ready low T+1..T+8.
//   MUL 0x10*0x10 -> 0x00, Z=1, C=1; SAR 0x90 by 2 -> 0xE4, C=0; SHL 0x81 by 1 -> 0x02, C=1.
//   Illegal op 0xF -> rsp_err=1, regs and flags unchanged; back-to-back cmd_valid held high -> one
//     accept per 2 cycles for EXEC ops, none dropped or duplicated.
//   Assert rst_n mid-MUL at T+4 -> all regs 0, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_regfile_seq.sv
// Register-file ALU datapath: valid/ready command port, one-cycle EXEC ops,
// an iterative shift-add multiply, registered flags and a response pulse.
module alu_regfile_seq #(
    parameter  int WIDTH  = 8,
    parameter  int NREGS  = 4,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic              cmd_use_imm,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [3:0]        flags,
    input  logic [ADDR_W-1:0] rd_sel,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int S     = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;
    localparam logic [3:0] OP_ADC = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   regs [NREGS];
    logic [3:0]         op_q;
    logic [ADDR_W-1:0]  rd_q;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   operand_b;
    logic               accept;

    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [CNT_W-1:0]   mul_cnt;
    logic [2*WIDTH-1:0] mul_sum;
    logic               mul_last;

    logic [WIDTH:0]        wide;
    logic signed [WIDTH:0] sar_wide;
    logic [S-1:0]          shamt;
    logic [WIDTH-1:0]      alu_res;
    logic                  alu_c;
    logic                  alu_v;
    logic                  alu_legal;

    logic                  done_en;
    logic [WIDTH-1:0]      done_res;
    logic                  done_c;
    logic                  done_v;
    logic                  done_legal;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign operand_b = cmd_use_imm ? cmd_imm : regs[cmd_rb];
    assign rd_data   = regs[rd_sel];
    assign shamt     = op_b[S-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (cmd_op == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC:    state_next = IDLE;
            MUL:     state_next = mul_last ? IDLE : MUL;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle ops work on the operands captured at accept; MUL never lands here.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        wide      = '0;
        sar_wide  = '0;
        case (op_q)
            OP_ADD: begin
                wide    = {1'b0, op_a} + {1'b0, op_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_ADC: begin
                wide    = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, flags[1]};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, op_a} - {1'b0, op_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = ~wide[WIDTH];
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_MOV: alu_res = op_b;
            // Shifts carry one guard bit so the last bit shifted out falls into it.
            OP_SHL: begin
                wide    = {1'b0, op_a} << shamt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {op_a, 1'b0} >> shamt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_SAR: begin
                sar_wide = $signed({op_a, 1'b0}) >>> shamt;
                alu_res  = sar_wide[WIDTH:1];
                alu_c    = sar_wide[0];
            end
            default: alu_legal = 1'b0;
        endcase
    end

    assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_last = (mul_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        done_en    = 1'b0;
        done_res   = alu_res;
        done_c     = alu_c;
        done_v     = alu_v;
        done_legal = alu_legal;
        if (state == EXEC) begin
            done_en = 1'b1;
        end else if (state == MUL) begin
            done_en    = mul_last;
            done_res   = mul_sum[WIDTH-1:0];
            done_c     = |mul_sum[2*WIDTH-1:WIDTH];
            done_v     = 1'b0;
            done_legal = 1'b1;
        end
    end

    // Operand capture, multiply iteration and the completion write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            op_q       <= '0;
            rd_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            flags      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                op_q       <= cmd_op;
                rd_q       <= cmd_rd;
                op_a       <= regs[cmd_ra];
                op_b       <= operand_b;
                mul_acc    <= '0;
                mul_mcand  <= {{WIDTH{1'b0}}, regs[cmd_ra]};
                mul_mplier <= operand_b;
                mul_cnt    <= '0;
            end
            if (state == MUL) begin
                mul_acc    <= mul_sum;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
            end
            if (done_en) begin
                rsp_valid <= 1'b1;
                if (done_legal) begin
                    regs[rd_q] <= done_res;
                    flags      <= {(done_res == '0), done_res[WIDTH-1], done_c, done_v};
                    rsp_data   <= done_res;
                    rsp_err    <= 1'b0;
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Directed bench for alu_regfile_seq: table of hand-computed commands, back-to-back
// handshake and reset during a multiply.
module tb_alu_regfile_seq;

    localparam int WIDTH = 8;
    localparam int NREGS = 4;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] XOR = 4'd4;
    localparam logic [3:0] NOT = 4'd5;
    localparam logic [3:0] SHL = 4'd6;
    localparam logic [3:0] SHR = 4'd7;
    localparam logic [3:0] SAR = 4'd8;
    localparam logic [3:0] MUL = 4'd9;
    localparam logic [3:0] MOV = 4'd10;
    localparam logic [3:0] ADC = 4'd11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [1:0]       cmd_rd;
    logic [1:0]       cmd_ra;
    logic [1:0]       cmd_rb;
    logic             cmd_use_imm;
    logic [7:0]       cmd_imm;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             rsp_err;
    logic [3:0]       flags;
    logic [1:0]       rd_sel;
    logic [7:0]       rd_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] model [NREGS];

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       ui;
        logic [7:0] imm;
        logic [7:0] data;
        logic       err;
        logic [3:0] fl;
        logic [3:0] lat;
    } vec_t;

    vec_t vecs [26];

    alu_regfile_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .flags       (flags),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command on an idle block and follow it to its response.
    task automatic applyStimulus(input vec_t v, input int idx);
        string t;
        int    lat;
        logic  ready_low;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_rd      = v.rd;
        cmd_ra      = v.ra;
        cmd_rb      = v.rb;
        cmd_use_imm = v.ui;
        cmd_imm     = v.imm;
        rd_sel      = v.rd;
        checkOutput({t, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput({t, "_prewrite"}, 32'(rd_data), 32'(model[v.rd]));
        lat       = 0;
        ready_low = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (cmd_ready) ready_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({t, "_latency"}, 32'(lat), 32'(v.lat));
        checkOutput({t, "_busy"}, 32'(ready_low), 32'd1);
        checkOutput({t, "_data"}, 32'(rsp_data), 32'(v.data));
        checkOutput({t, "_err"}, 32'(rsp_err), 32'(v.err));
        checkOutput({t, "_flags"}, 32'(flags), 32'(v.fl));
        if (!v.err) model[v.rd] = v.data;
        checkOutput({t, "_rd"}, 32'(rd_data), 32'(model[v.rd]));
    endtask

    initial begin
        int   acc_cycle [4];
        int   n_acc;
        int   n_rsp;
        int   n_late;
        logic rdy;
        logic [7:0] rsp_seen [4];

        //            op   rd    ra    rb    ui    imm    data   err   flags    lat
        vecs = '{
            '{MOV, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h7F, 1'b0, 4'b0000, 4'd1},
            '{ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 8'h80, 1'b0, 4'b0101, 4'd1},
            '{MOV, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 4'b1000, 4'd1},
            '{SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'hFF, 1'b0, 4'b0100, 4'd1},
            '{ADC, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 8'hFF, 1'b0, 4'b0100, 4'd1},
            '{SUB, 2'd1, 2'd2, 2'd0, 1'b1, 8'h01, 8'hFE, 1'b0, 4'b0110, 4'd1},
            '{ADC, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0, 4'b1010, 4'd1},
            '{MOV, 2'd0, 2'd0, 2'd0, 1'b1, 8'h0D, 8'h0D, 1'b0, 4'b0000, 4'd1},
            '{MOV, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0B, 8'h0B, 1'b0, 4'b0000, 4'd1},
            '{MUL, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h8F, 1'b0, 4'b0100, 4'd8},
            '{MOV, 2'd0, 2'd0, 2'd0, 1'b1, 8'h10, 8'h10, 1'b0, 4'b0000, 4'd1},
            '{MUL, 2'd3, 2'd0, 2'd0, 1'b1, 8'h10, 8'h00, 1'b0, 4'b1010, 4'd8},
            '{MOV, 2'd0, 2'd0, 2'd0, 1'b1, 8'h90, 8'h90, 1'b0, 4'b0100, 4'd1},
            '{SAR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h02, 8'hE4, 1'b0, 4'b0100, 4'd1},
            '{MOV, 2'd0, 2'd0, 2'd0, 1'b1, 8'h81, 8'h81, 1'b0, 4'b0100, 4'd1},
            '{SHL, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 8'h02, 1'b0, 4'b0010, 4'd1},
            '{SHR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h09, 8'h40, 1'b0, 4'b0010, 4'd1},
            '{SHL, 2'd1, 2'd0, 2'd0, 1'b1, 8'h08, 8'h81, 1'b0, 4'b0100, 4'd1},
            '{XOR, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 8'h7E, 1'b0, 4'b0000, 4'd1},
            '{NOT, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00, 8'h7E, 1'b0, 4'b0000, 4'd1},
            '{AND, 2'd3, 2'd0, 2'd0, 1'b1, 8'h0F, 8'h01, 1'b0, 4'b0000, 4'd1},
            '{OR,  2'd3, 2'd0, 2'd0, 1'b1, 8'h0F, 8'h8F, 1'b0, 4'b0100, 4'd1},
            '{MOV, 2'd3, 2'd0, 2'd2, 1'b0, 8'h00, 8'h7E, 1'b0, 4'b0000, 4'd1},
            '{ADD, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h02, 1'b0, 4'b0011, 4'd1},
            '{4'hF, 2'd0, 2'd0, 2'd0, 1'b1, 8'h55, 8'h00, 1'b1, 4'b0011, 4'd1},
            '{4'hC, 2'd1, 2'd0, 2'd0, 1'b1, 8'h55, 8'h00, 1'b1, 4'b0011, 4'd1}
        };

        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_rd      = 2'd0;
        cmd_ra      = 2'd0;
        cmd_rb      = 2'd0;
        cmd_use_imm = 1'b0;
        cmd_imm     = 8'h00;
        rd_sel      = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        for (int r = 0; r < NREGS; r++) begin
            rd_sel = 2'(r);
            #1;
            checkOutput($sformatf("rst_r%0d", r), 32'(rd_data), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) applyStimulus(vecs[i], i);

        // Back-to-back MOVs with cmd_valid held high the whole time.
        n_acc = 0;
        n_rsp = 0;
        for (int k = 0; k < 4; k++) begin
            acc_cycle[k] = 0;
            rsp_seen[k]  = 8'h00;
        end
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (n_acc < 4) begin
                cmd_valid   = 1'b1;
                cmd_op      = MOV;
                cmd_rd      = 2'(n_acc);
                cmd_use_imm = 1'b1;
                cmd_imm     = 8'(17 * (n_acc + 1));
            end else begin
                cmd_valid = 1'b0;
            end
            rdy = cmd_ready;
            @(posedge clk);
            if (cmd_valid && rdy) begin
                acc_cycle[n_acc] = cyc;
                n_acc++;
            end
            #1;
            if (rsp_valid) begin
                if (n_rsp < 4) rsp_seen[n_rsp] = rsp_data;
                n_rsp++;
            end
        end
        cmd_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(n_acc), 32'd4);
        checkOutput("b2b_responses", 32'(n_rsp), 32'd4);
        for (int k = 1; k < 4; k++)
            checkOutput($sformatf("b2b_gap%0d", k), 32'(acc_cycle[k] - acc_cycle[k-1]), 32'd2);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b2b_rsp%0d", k), 32'(rsp_seen[k]), 32'(8'(17 * (k + 1))));
            rd_sel = 2'(k);
            #1;
            checkOutput($sformatf("b2b_r%0d", k), 32'(rd_data), 32'(8'(17 * (k + 1))));
        end

        // Reset asserted four cycles into a multiply.
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = MUL;
        cmd_rd      = 2'd0;
        cmd_ra      = 2'd1;
        cmd_use_imm = 1'b1;
        cmd_imm     = 8'h03;
        checkOutput("mrst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_ready_low", 32'(cmd_ready), 32'd1);
        checkOutput("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mrst_flags", 32'(flags), 32'd0);
        for (int r = 0; r < NREGS; r++) begin
            rd_sel = 2'(r);
            #1;
            checkOutput($sformatf("mrst_r%0d", r), 32'(rd_data), 32'd0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        n_late = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n_late++;
        end
        checkOutput("mrst_no_rsp", 32'(n_late), 32'd0);
        checkOutput("mrst_ready_after", 32'(cmd_ready), 32'd1);
        rd_sel = 2'd0;
        #1;
        checkOutput("mrst_r0_after", 32'(rd_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
